seq_divider: RTL and testbench

Parametrised multi-cycle integer divider for the CPU execute stage, implementing all four RISC-V M-extension division ops (DIV, DIVU, REM, REMU) at configurable width. It produces one quotient bit per cycle by restoring division, applies RISC-V divide-by-zero and signed-overflow rules, and talks to the pipeline through an explicit start/ready/done handshake with a flush input. It supersedes the fixed 32-bit unsigned change-triggered divider.

---
 rtl/div_pkg.sv | 30 +++
 rtl/seq_divider_if.sv | 31 +++
 rtl/div_step.sv | 29 ++
 rtl/seq_divider.sv | 154 +++++++++++++++
 tb/tb_seq_divider.sv | 472 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// ---------------------------------------------------------------------------
// div_pkg
// Shared definitions for the sequential divider: RISC-V M-extension divide
// op encodings (funct3[1:0]), FSM state encoding and small op-decode helpers.
// ---------------------------------------------------------------------------
package div_pkg;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // DIV and REM treat their operands as two's complement.
  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  // REM and REMU return the remainder on the result port.
  function automatic logic op_is_rem(input logic [1:0] op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/seq_divider_if.sv
// ---------------------------------------------------------------------------
// seq_divider_if
// Pipeline-side handshake bundle for seq_divider.
//   master : start, op, dividend, divisor, flush  -> divider
//   slave  : ready, busy, done, quotient, remainder, result -> pipeline
// ---------------------------------------------------------------------------
interface seq_divider_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             flush;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic [WIDTH-1:0] result;

  modport master (
    output start, op, dividend, divisor, flush,
    input  ready, busy, done, quotient, remainder, result
  );

  modport slave (
    input  start, op, dividend, divisor, flush,
    output ready, busy, done, quotient, remainder, result
  );
endinterface

// File: rtl/div_step.sv
// ---------------------------------------------------------------------------
// div_step
// One combinational restoring-division step.
//   i_rem     : current partial remainder (WIDTH bits)
//   i_bit     : next dividend bit shifted in
//   i_divisor : divisor magnitude
//   o_rem     : next partial remainder
//   o_q_bit   : quotient bit produced by this step
// ---------------------------------------------------------------------------
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_q_bit
);
  logic [WIDTH:0] w_partial;
  logic [WIDTH:0] w_diff;

  assign w_partial = {i_rem, i_bit};
  assign w_diff    = w_partial - {1'b0, i_divisor};

  // The partial remainder is always below twice the divisor, so a
  // non-negative difference fits in WIDTH bits and bit WIDTH is the sign.
  assign o_q_bit = ~w_diff[WIDTH];
  assign o_rem   = o_q_bit ? w_diff[WIDTH-1:0] : w_partial[WIDTH-1:0];
endmodule

// File: rtl/seq_divider.sv
// ---------------------------------------------------------------------------
// seq_divider
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU, one quotient bit per
// cycle, with RISC-V divide-by-zero and signed-overflow results.
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : seq_divider_if.slave (start/op/operands/flush in,
//           ready/busy/done/quotient/remainder/result out)
// ---------------------------------------------------------------------------
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         reset,
  seq_divider_if.slave bus
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           r_state;
  logic [1:0]       r_op;
  logic             r_neg_q;
  logic             r_neg_r;
  logic [WIDTH-1:0] r_divisor;
  logic [WIDTH-1:0] r_q;        // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] r_rem;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ready;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic [WIDTH-1:0] r_result;

  logic             w_signed;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic             w_div_zero;
  logic             w_overflow;
  logic [WIDTH-1:0] w_step_rem;
  logic             w_q_bit;
  logic [WIDTH-1:0] w_fix_q;
  logic [WIDTH-1:0] w_fix_r;

  assign w_signed   = op_is_signed(bus.op);
  assign w_a_neg    = w_signed & bus.dividend[WIDTH-1];
  assign w_b_neg    = w_signed & bus.divisor[WIDTH-1];
  assign w_a_mag    = w_a_neg ? -bus.dividend : bus.dividend;
  assign w_b_mag    = w_b_neg ? -bus.divisor : bus.divisor;
  assign w_div_zero = (bus.divisor == '0);
  assign w_overflow = w_signed && (bus.dividend == MOST_NEG) && (bus.divisor == '1);

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem     (r_rem),
    .i_bit     (r_q[WIDTH-1]),
    .i_divisor (r_divisor),
    .o_rem     (w_step_rem),
    .o_q_bit   (w_q_bit)
  );

  assign w_fix_q = r_neg_q ? -r_q : r_q;
  assign w_fix_r = r_neg_r ? -r_rem : r_rem;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_op        <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_divisor   <= '0;
      r_q         <= '0;
      r_rem       <= '0;
      r_cnt       <= '0;
      r_ready     <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_result    <= '0;
    end else if (bus.flush) begin
      // Abort: working state is simply abandoned, outputs keep old values.
      r_state <= IDLE;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_op    <= bus.op;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            if (w_div_zero || w_overflow) begin
              // Special cases bypass CALC but still pass through FIX so the
              // outputs only ever load on the edge entering DONE.
              r_state <= FIX;
              r_neg_q <= 1'b0;
              r_neg_r <= 1'b0;
              r_q     <= w_div_zero ? '1 : MOST_NEG;
              r_rem   <= w_div_zero ? bus.dividend : '0;
            end else begin
              r_state   <= CALC;
              r_neg_q   <= w_a_neg ^ w_b_neg;
              r_neg_r   <= w_a_neg;
              r_q       <= w_a_mag;
              r_rem     <= '0;
              r_divisor <= w_b_mag;
              r_cnt     <= CNT_W'(WIDTH - 1);
            end
          end else begin
            r_state <= IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        CALC: begin
          r_rem <= w_step_rem;
          r_q   <= {r_q[WIDTH-2:0], w_q_bit};
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) begin
            r_state <= FIX;
          end
        end
        FIX: begin
          r_quotient  <= w_fix_q;
          r_remainder <= w_fix_r;
          r_result    <= op_is_rem(r_op) ? w_fix_r : w_fix_q;
          r_state     <= DONE;
          r_ready     <= 1'b1;
          r_busy      <= 1'b0;
          r_done      <= 1'b1;
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready     = r_ready;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.quotient  = r_quotient;
  assign bus.remainder = r_remainder;
  assign bus.result    = r_result;
endmodule

// File: tb/tb_seq_divider.sv
// ---------------------------------------------------------------------------
// tb_seq_divider
// Self-checking bench: a 32-bit instance for directed scenarios and an 8-bit
// instance for a random sweep against a reference model. Expected results are
// queued when an operation is issued and popped when done is observed.
// ---------------------------------------------------------------------------
module tb_seq_divider;
  import div_pkg::*;

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
    logic [31:0] res;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  exp_t sb32[$];
  exp_t sb8[$];

  always #5 clk = ~clk;

  seq_divider_if #(.WIDTH(32)) bus32 ();
  seq_divider_if #(.WIDTH(8))  bus8 ();

  seq_divider #(.WIDTH(32)) dut32 (.clk(clk), .reset(rst_n), .bus(bus32));
  seq_divider #(.WIDTH(8))  dut8  (.clk(clk), .reset(rst_n), .bus(bus8));

  function automatic exp_t mk_exp(input logic [1:0] op, input logic [31:0] q, input logic [31:0] r);
    exp_t e;
    e.q   = q;
    e.r   = r;
    e.res = ((op == OP_REM) || (op == OP_REMU)) ? r : q;
    return e;
  endfunction

  // Reference model for the 8-bit instance, built on native SV arithmetic.
  function automatic exp_t model8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    int sa;
    int sb;
    logic [7:0] q;
    logic [7:0] r;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (b == 8'h00) begin
      q = 8'hFF;
      r = a;
    end else if ((op == OP_DIV || op == OP_REM) && a == 8'h80 && b == 8'hFF) begin
      q = 8'h80;
      r = 8'h00;
    end else if (op == OP_DIV || op == OP_REM) begin
      q = 8'(sa / sb);
      r = 8'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
    return mk_exp(op, {24'h0, q}, {24'h0, r});
  endfunction

  // Drives one start pulse on the 32-bit bus; returns 1 ns after the accepting edge.
  task automatic issue32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er);
    bus32.op       = op;
    bus32.dividend = a;
    bus32.divisor  = b;
    bus32.start    = 1'b1;
    sb32.push_back(mk_exp(op, eq, er));
    @(posedge clk);
    #1;
    bus32.start = 1'b0;
  endtask

  // Counts edges (the accepting edge is 1) until done is seen or the budget expires.
  task automatic wait_done32(input int max_cyc, output int cyc, output bit seen);
    cyc  = 1;
    seen = 1'b0;
    while (!seen && cyc < max_cyc) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus32.done === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic wait_done8(input int max_cyc, output int cyc, output bit seen);
    cyc  = 1;
    seen = 1'b0;
    while (!seen && cyc < max_cyc) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus8.done === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic pop32(output exp_t e);
    if (sb32.size() == 0) begin
      e = '0;
      errors++;
      $display("FAIL scoreboard32_empty: queue size=0 required >0");
    end else begin
      e = sb32.pop_front();
    end
  endtask

  task automatic test_reset();
    checks++;
    if (bus32.ready !== 1'b1 || bus32.busy !== 1'b0 || bus32.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: ready=%b busy=%b done=%b required 1 0 0", bus32.ready, bus32.busy, bus32.done);
    end
    checks++;
    if (bus32.quotient !== 32'h0 || bus32.remainder !== 32'h0 || bus32.result !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: q=%h r=%h res=%h required 0 0 0", bus32.quotient, bus32.remainder, bus32.result);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus8.ready !== 1'b1 || bus8.busy !== 1'b0 || bus8.done !== 1'b0 || bus8.quotient !== 8'h0) begin
      errors++;
      $display("FAIL reset_w8: ready=%b busy=%b done=%b q=%h required 1 0 0 00", bus8.ready, bus8.busy, bus8.done, bus8.quotient);
    end
    $display("txn reset released");
  endtask

  task automatic test_divu();
    int cyc;
    bit seen;
    exp_t e;
    issue32(OP_DIVU, 32'd100, 32'd7, 32'd14, 32'd2);
    checks++;
    if (bus32.busy !== 1'b1 || bus32.ready !== 1'b0) begin
      errors++;
      $display("FAIL divu_busy: busy=%b ready=%b required busy=1 ready=0", bus32.busy, bus32.ready);
    end
    wait_done32(60, cyc, seen);
    checks++;
    if (!seen || cyc != 34) begin
      errors++;
      $display("FAIL divu_latency: seen=%b cycles=%0d required 34", seen, cyc);
    end
    pop32(e);
    checks++;
    if (bus32.quotient !== e.q || bus32.remainder !== e.r || bus32.result !== e.res) begin
      errors++;
      $display("FAIL divu_value: q=%h r=%h res=%h required %h %h %h", bus32.quotient, bus32.remainder, bus32.result, e.q, e.r, e.res);
    end
    $display("txn DIVU 100/7 q=%0d r=%0d res=%0d lat=%0d", bus32.quotient, bus32.remainder, bus32.result, cyc);
    @(posedge clk);
    #1;
    checks++;
    if (bus32.done !== 1'b0 || bus32.ready !== 1'b1 || bus32.quotient !== 32'd14) begin
      errors++;
      $display("FAIL divu_pulse: done=%b ready=%b q=%h required 0 1 0000000e", bus32.done, bus32.ready, bus32.quotient);
    end
  endtask

  task automatic test_signed();
    int cyc;
    bit seen;
    exp_t e;
    logic [1:0] ops [2];
    ops[0] = OP_DIV;
    ops[1] = OP_REM;
    for (int i = 0; i < 2; i++) begin
      issue32(ops[i], 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
      wait_done32(60, cyc, seen);
      checks++;
      if (!seen || cyc != 34) begin
        errors++;
        $display("FAIL signed_latency: op=%0d seen=%b cycles=%0d required 34", ops[i], seen, cyc);
      end
      pop32(e);
      checks++;
      if (bus32.quotient !== e.q || bus32.remainder !== e.r || bus32.result !== e.res) begin
        errors++;
        $display("FAIL signed_value: op=%0d q=%h r=%h res=%h required %h %h %h", ops[i], bus32.quotient, bus32.remainder, bus32.result, e.q, e.r, e.res);
      end
      $display("txn op=%0d -7/2 q=%h r=%h res=%h lat=%0d", ops[i], bus32.quotient, bus32.remainder, bus32.result, cyc);
    end
  endtask

  task automatic test_div_zero();
    int cyc;
    bit seen;
    exp_t e;
    issue32(OP_REMU, 32'd7, 32'd0, 32'hFFFF_FFFF, 32'd7);
    checks++;
    if (bus32.busy !== 1'b1 || bus32.done !== 1'b0) begin
      errors++;
      $display("FAIL div0_busy: busy=%b done=%b required 1 0", bus32.busy, bus32.done);
    end
    wait_done32(10, cyc, seen);
    checks++;
    if (!seen || cyc != 2) begin
      errors++;
      $display("FAIL div0_latency: seen=%b cycles=%0d required 2", seen, cyc);
    end
    pop32(e);
    checks++;
    if (bus32.quotient !== e.q || bus32.remainder !== e.r || bus32.result !== e.res) begin
      errors++;
      $display("FAIL div0_remu: q=%h r=%h res=%h required %h %h %h", bus32.quotient, bus32.remainder, bus32.result, e.q, e.r, e.res);
    end
    $display("txn REMU 7/0 q=%h r=%h res=%h lat=%0d", bus32.quotient, bus32.remainder, bus32.result, cyc);
    issue32(OP_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9);
    wait_done32(10, cyc, seen);
    pop32(e);
    checks++;
    if (!seen || cyc != 2 || bus32.quotient !== e.q || bus32.remainder !== e.r || bus32.result !== e.res) begin
      errors++;
      $display("FAIL div0_div: lat=%0d q=%h r=%h res=%h required 2 %h %h %h", cyc, bus32.quotient, bus32.remainder, bus32.result, e.q, e.r, e.res);
    end
    $display("txn DIV -7/0 q=%h r=%h res=%h lat=%0d", bus32.quotient, bus32.remainder, bus32.result, cyc);
  endtask

  task automatic test_overflow();
    int cyc;
    bit seen;
    exp_t e;
    logic [1:0] ops [2];
    ops[0] = OP_DIV;
    ops[1] = OP_REM;
    for (int i = 0; i < 2; i++) begin
      issue32(ops[i], 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0);
      wait_done32(10, cyc, seen);
      checks++;
      if (!seen || cyc != 2) begin
        errors++;
        $display("FAIL ovf_latency: op=%0d seen=%b cycles=%0d required 2", ops[i], seen, cyc);
      end
      pop32(e);
      checks++;
      if (bus32.quotient !== e.q || bus32.remainder !== e.r || bus32.result !== e.res) begin
        errors++;
        $display("FAIL ovf_value: op=%0d q=%h r=%h res=%h required %h %h %h", ops[i], bus32.quotient, bus32.remainder, bus32.result, e.q, e.r, e.res);
      end
      $display("txn op=%0d 0x80000000/-1 q=%h r=%h res=%h lat=%0d", ops[i], bus32.quotient, bus32.remainder, bus32.result, cyc);
    end
  endtask

  // Entered with outputs holding REM 0x80000000/-1: q=0x80000000 r=0 res=0.
  task automatic test_flush();
    int dones;
    bus32.op       = OP_DIVU;
    bus32.dividend = 32'd1000;
    bus32.divisor  = 32'd10;
    bus32.start    = 1'b1;
    @(posedge clk);
    #1;
    bus32.start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    bus32.flush = 1'b1;
    @(posedge clk);
    #1;
    bus32.flush = 1'b0;
    checks++;
    if (bus32.busy !== 1'b0 || bus32.ready !== 1'b1 || bus32.done !== 1'b0) begin
      errors++;
      $display("FAIL flush_ctrl: busy=%b ready=%b done=%b required 0 1 0", bus32.busy, bus32.ready, bus32.done);
    end
    dones = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus32.done === 1'b1) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL flush_no_done: done pulses=%0d required 0", dones);
    end
    checks++;
    if (bus32.quotient !== 32'h8000_0000 || bus32.remainder !== 32'h0 || bus32.result !== 32'h0) begin
      errors++;
      $display("FAIL flush_hold: q=%h r=%h res=%h required 80000000 0 0", bus32.quotient, bus32.remainder, bus32.result);
    end
    $display("txn DIVU 1000/10 flushed at cycle 10");
    bus32.dividend = 32'd9;
    bus32.divisor  = 32'd3;
    bus32.start    = 1'b1;
    bus32.flush    = 1'b1;
    @(posedge clk);
    #1;
    bus32.start = 1'b0;
    bus32.flush = 1'b0;
    checks++;
    if (bus32.busy !== 1'b0 || bus32.ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_start: busy=%b ready=%b required 0 1", bus32.busy, bus32.ready);
    end
    dones = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus32.done === 1'b1) dones++;
    end
    checks++;
    if (dones != 0 || bus32.quotient !== 32'h8000_0000) begin
      errors++;
      $display("FAIL flush_start_no_done: done pulses=%0d q=%h required 0 80000000", dones, bus32.quotient);
    end
    $display("txn DIVU 9/3 start with flush ignored");
  endtask

  task automatic test_back_to_back();
    int cyc;
    bit seen;
    exp_t e;
    bus32.op       = OP_DIVU;
    bus32.dividend = 32'd9;
    bus32.divisor  = 32'd3;
    bus32.start    = 1'b1;
    sb32.push_back(mk_exp(OP_DIVU, 32'd3, 32'd0));
    @(posedge clk);
    #1;
    // start stays high through CALC with new operands: must not disturb op 1
    bus32.dividend = 32'd10;
    bus32.divisor  = 32'd4;
    sb32.push_back(mk_exp(OP_DIVU, 32'd2, 32'd2));
    wait_done32(60, cyc, seen);
    pop32(e);
    checks++;
    if (!seen || cyc != 34 || bus32.quotient !== e.q || bus32.remainder !== e.r || bus32.result !== e.res) begin
      errors++;
      $display("FAIL b2b_first: lat=%0d q=%h r=%h res=%h required 34 %h %h %h", cyc, bus32.quotient, bus32.remainder, bus32.result, e.q, e.r, e.res);
    end
    $display("txn DIVU 9/3 q=%0d r=%0d lat=%0d", bus32.quotient, bus32.remainder, cyc);
    @(posedge clk);
    #1;
    bus32.start = 1'b0;
    checks++;
    if (bus32.busy !== 1'b1 || bus32.ready !== 1'b0 || bus32.done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept: busy=%b ready=%b done=%b required 1 0 0", bus32.busy, bus32.ready, bus32.done);
    end
    wait_done32(60, cyc, seen);
    pop32(e);
    checks++;
    if (!seen || cyc != 34 || bus32.quotient !== e.q || bus32.remainder !== e.r || bus32.result !== e.res) begin
      errors++;
      $display("FAIL b2b_second: lat=%0d q=%h r=%h res=%h required 34 %h %h %h", cyc, bus32.quotient, bus32.remainder, bus32.result, e.q, e.r, e.res);
    end
    $display("txn DIVU 10/4 q=%0d r=%0d lat=%0d", bus32.quotient, bus32.remainder, cyc);
  endtask

  task automatic test_random8();
    int cyc;
    bit seen;
    bit special;
    int sel;
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    exp_t e;
    for (int n = 0; n < 120; n++) begin
      op  = 2'($urandom_range(0, 3));
      a   = 8'($urandom);
      b   = 8'($urandom);
      sel = $urandom_range(0, 9);
      if (sel == 0) begin
        b = 8'h00;
      end else if (sel == 1) begin
        a = 8'h80;
        b = 8'hFF;
      end
      special = (b == 8'h00) || ((op == OP_DIV || op == OP_REM) && a == 8'h80 && b == 8'hFF);
      bus8.op       = op;
      bus8.dividend = a;
      bus8.divisor  = b;
      bus8.start    = 1'b1;
      sb8.push_back(model8(op, a, b));
      @(posedge clk);
      #1;
      bus8.start = 1'b0;
      wait_done8(30, cyc, seen);
      checks++;
      if (!seen || cyc != (special ? 2 : 10)) begin
        errors++;
        $display("FAIL rand8_latency: op=%0d a=%h b=%h seen=%b cycles=%0d required %0d", op, a, b, seen, cyc, special ? 2 : 10);
      end
      if (sb8.size() == 0) begin
        e = '0;
        errors++;
        $display("FAIL scoreboard8_empty: queue size=0 required >0");
      end else begin
        e = sb8.pop_front();
      end
      checks++;
      if ({24'h0, bus8.quotient} !== e.q || {24'h0, bus8.remainder} !== e.r || {24'h0, bus8.result} !== e.res) begin
        errors++;
        $display("FAIL rand8_value: op=%0d a=%h b=%h q=%h r=%h res=%h required %h %h %h", op, a, b, bus8.quotient, bus8.remainder, bus8.result, e.q[7:0], e.r[7:0], e.res[7:0]);
      end
      $display("txn w8 op=%0d a=%h b=%h q=%h r=%h res=%h lat=%0d", op, a, b, bus8.quotient, bus8.remainder, bus8.result, cyc);
    end
  endtask

  task automatic test_reset_mid();
    int dones;
    bus32.op       = OP_DIVU;
    bus32.dividend = 32'd100;
    bus32.divisor  = 32'd7;
    bus32.start    = 1'b1;
    @(posedge clk);
    #1;
    bus32.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (bus32.busy !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_busy: busy=%b required 1", bus32.busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus32.ready !== 1'b1 || bus32.busy !== 1'b0 || bus32.done !== 1'b0 ||
        bus32.quotient !== 32'h0 || bus32.remainder !== 32'h0 || bus32.result !== 32'h0) begin
      errors++;
      $display("FAIL rstmid_values: ready=%b busy=%b done=%b q=%h r=%h res=%h required 1 0 0 0 0 0", bus32.ready, bus32.busy, bus32.done, bus32.quotient, bus32.remainder, bus32.result);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    dones = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus32.done === 1'b1) dones++;
    end
    checks++;
    if (dones != 0 || bus32.busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_no_done: done pulses=%0d busy=%b required 0 0", dones, bus32.busy);
    end
    $display("txn DIVU 100/7 reset mid-CALC");
  endtask

  initial begin
    bus32.start    = 1'b0;
    bus32.op       = OP_DIVU;
    bus32.dividend = '0;
    bus32.divisor  = '0;
    bus32.flush    = 1'b0;
    bus8.start     = 1'b0;
    bus8.op        = OP_DIVU;
    bus8.dividend  = '0;
    bus8.divisor   = '0;
    bus8.flush     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_divu();
    test_signed();
    test_div_zero();
    test_overflow();
    test_flush();
    test_back_to_back();
    test_random8();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
